// File: rtl/div_pkg.sv
// Shared definitions for the signed divider sequencer: state encoding,
// datapath sizing and the divide-by-zero quotient.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Start/done handshake plus operand and result buses between the execute
// stage (master) and the divider sequencer (slave).
interface div_sequencer_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One unsigned restoring division step. The caller has already shifted the
// next dividend bit into the partial remainder.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] dvs,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] diff;
  logic           ge;

  // Trial subtraction; no borrow out means the divisor fits
  always_comb begin
    diff   = pr - {1'b0, dvs};
    ge     = ~diff[WIDTH];
    r_next = ge ? diff[WIDTH-1:0] : pr[WIDTH-1:0];
    q_next = {q_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed divider controller: captures operands, runs one
// restoring step per clock for WIDTH iterations, then fixes up signs.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, prem, quo;
  logic [CNT_W-1:0] cnt;
  logic             qneg, rneg;
  logic [WIDTH-1:0] q_out, r_out;
  logic             dz_out;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             div_zero, early_out;
  logic [WIDTH-1:0] step_r, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr     ({prem, dvd_mag[WIDTH-1]}),
    .dvs    (dvs_mag),
    .q_in   (quo),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Operand magnitudes and the short-path decisions taken in IDLE
  always_comb begin
    dvd_abs  = bus.dividend[WIDTH-1] ? (~bus.dividend + ONE) : bus.dividend;
    dvs_abs  = bus.divisor[WIDTH-1]  ? (~bus.divisor + ONE)  : bus.divisor;
    div_zero = (bus.divisor == '0);
`ifdef DIV_EARLY_OUT_EN
    early_out = (dvd_abs < dvs_abs);
`else
    early_out = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    unique case (state)
      IDLE: if (bus.start) state_nxt = (div_zero || early_out) ? DONE : ITER;
      ITER: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_mag <= '0;
      dvs_mag <= '0;
      prem    <= '0;
      quo     <= '0;
      cnt     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      dz_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          dz_out <= 1'b0;
          if (div_zero) begin
            q_out  <= DIV_ZERO_QUOT;
            r_out  <= bus.dividend;
            dz_out <= 1'b1;
          end else if (early_out) begin
            q_out <= '0;
            r_out <= bus.dividend;
          end else begin
            qneg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg    <= bus.dividend[WIDTH-1];
            dvd_mag <= dvd_abs;
            dvs_mag <= dvs_abs;
            prem    <= '0;
            quo     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
          end
        end
        ITER: begin
          prem    <= step_r;
          quo     <= step_q;
          dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CNT_ONE;
        end
        FIX: begin
          q_out <= qneg ? (~quo + ONE) : quo;
          r_out <= rneg ? (~prem + ONE) : prem;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned bcnt = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic int unsigned exp_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(a) < mag(b)) return 1;
`endif
    return 34;
  endfunction

  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
    logic signed [31:0] sa, sd;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else begin
      sa = a; sd = b;
      q = sa / sd;
      r = sa % sd;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt      = 0;
        prev_done = 1'b0;
      end else begin
        if (bus.busy) bcnt++;
        else          bcnt = 0;
        if (bus.done) begin
          chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
            chk("latency", cyc - e.t0, e.lat);
            chk("busy_cycles", bcnt, e.lat);
          end
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz,
                       input bit push, output int unsigned t0);
    exp_t e;
    wait_idle();
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    t0           = cyc;
    if (push) begin
      e.q = q; e.r = r; e.dz = dz; e.lat = exp_lat(a, b); e.t0 = t0;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  vec_t vecs [12] = '{
    '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
    '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0},
    '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0},
    '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
    '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0},
    '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1},
    '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0},
    '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0},
    '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0},
    '{32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1},
    '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0},
    '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0}
  };

  initial begin
    int unsigned t0;
    logic [31:0] a, b, q, r;
    logic        dz;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back
    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1, t0);

    // A start pulsed mid-operation must be ignored
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, t0);
    repeat (9) @(negedge clk);
    bus.dividend = 32'd5;
    bus.divisor  = 32'd0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Reset in the middle of an operation abandons it
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, t0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_quotient", bus.quotient, 32'd0);
    chk("abort_remainder", bus.remainder, 32'd0);
    issue(32'd3, 32'd9, 32'd0, 32'd3, 1'b0, 1'b1, t0);

    // Random signed pairs, back-to-back
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(31, 0);
      if (i % 4 == 2) a = a >>> $urandom_range(31, 20);
      if (i % 8 == 3) b = 32'd0;
      ref_model(a, b, q, r, dz);
      issue(a, b, q, r, dz, 1'b1, t0);
    end

    // Drain the scoreboard
    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results never arrived", sb.size());
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
